// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hold/flush sequencer for the 5-stage RV32I core, with
// load-use, redirect and memory-freeze handling plus hazard performance counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             hold_idex,
    output logic             hold_exmem,
    output logic             hold_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_memwait,
    output logic [CNT_W-1:0] cnt_flush
);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, HALT = 2'd2} state_t;

    state_t          state_q;
    logic [WW-1:0]   wait_q;
    logic            mem_err_q;
    logic [CNT_W-1:0] cnt_lu_q, cnt_mw_q, cnt_fl_q;
    logic            freeze, lu, halt, r_frz, r_red, r_lu;

    assign freeze = mem_req & ~mem_ready;
    assign lu     = ex_MemRead & (ex_rd != 5'd0) & id_valid &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    assign halt   = state_q == HALT;

    // One-hot row selection in priority order: halt, freeze, redirect, load-use.
    assign r_frz  = ~halt & freeze;
    assign r_red  = ~halt & ~freeze & ex_redirect;
    assign r_lu   = ~halt & ~freeze & ~ex_redirect & lu;

    assign hold_pc     = ~reset & (halt | freeze | r_lu);
    assign hold_ifid   = ~reset & (halt | freeze | r_lu);
    assign hold_idex   = ~reset & (halt | freeze);
    assign hold_exmem  = ~reset & (halt | freeze);
    assign hold_memwb  = ~reset & (halt | freeze);
    assign flush_ifid  = ~reset & r_red;
    assign flush_idex  = ~reset & (r_red | r_lu);
    assign mem_err     = mem_err_q;
    assign state       = state_q;
    assign cnt_loaduse = cnt_lu_q;
    assign cnt_memwait = cnt_mw_q;
    assign cnt_flush   = cnt_fl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            cnt_lu_q  <= '0;
            cnt_mw_q  <= '0;
            cnt_fl_q  <= '0;
        end else begin
            case (state_q)
                RUN: if (freeze) begin
                    state_q <= MEMWAIT;
                    wait_q  <= WW'(1);
                end
                // A dropped mem_req counts as completion, same as mem_ready.
                MEMWAIT: if (!freeze) begin
                    state_q <= RUN;
                    wait_q  <= '0;
                end else if (wait_q == LAST) begin
                    state_q   <= HALT;
                    mem_err_q <= 1'b1;
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
                default: ;
            endcase
            cnt_lu_q <= cnt_lu_q + CNT_W'(r_lu);
            cnt_mw_q <= cnt_mw_q + CNT_W'(r_frz);
            cnt_fl_q <= cnt_fl_q + CNT_W'(r_red);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic id_valid, id_rs1_used, id_rs2_used, ex_MemRead, ex_redirect, mem_req, mem_ready;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb, flush_ifid, flush_idex, mem_err;
    logic [1:0] state;
    logic [31:0] cnt_loaduse, cnt_memwait, cnt_flush;
    logic [6:0] outs;
    int checks = 0, errors = 0;

    hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_MemRead(ex_MemRead),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
        .hold_exmem(hold_exmem), .hold_memwb(hold_memwb), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .mem_err(mem_err), .state(state),
        .cnt_loaduse(cnt_loaduse), .cnt_memwait(cnt_memwait), .cnt_flush(cnt_flush)
    );

    always #5 clk = ~clk;
    assign outs = {hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb, flush_ifid, flush_idex};

    typedef struct {
        logic v; logic [4:0] rs1, rs2; logic u1, u2, mr; logic [4:0] rd;
        logic red, mreq, mrdy; logic [6:0] exp; logic [2:0] cnt;
    } vec_t;
    vec_t tv [13];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_MemRead = 0; ex_rd = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); clr(); reset = 1;
        @(negedge clk); reset = 0;
    endtask

    initial begin
        int e_lu, e_mw, e_fl;
        // {v, rs1, rs2, u1, u2, mr, rd, red, mreq, mrdy, exp{pc,ifid,idex,exmem,memwb,fifid,fidex}, cnt{lu,mw,fl}}
        tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 3'b000};
        tv[1]  = '{1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 7'b1100001, 3'b100};
        tv[2]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 7'b0000000, 3'b000};
        tv[3]  = '{1, 0, 5, 0, 0, 1, 5, 0, 0, 0, 7'b0000000, 3'b000};
        tv[4]  = '{1, 7, 0, 1, 0, 1, 7, 0, 0, 0, 7'b1100001, 3'b100};
        tv[5]  = '{0, 7, 0, 1, 0, 1, 7, 0, 0, 0, 7'b0000000, 3'b000};
        tv[6]  = '{1, 7, 0, 1, 0, 0, 7, 0, 0, 0, 7'b0000000, 3'b000};
        tv[7]  = '{1, 0, 5, 0, 1, 1, 5, 1, 0, 0, 7'b0000011, 3'b001};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000011, 3'b001};
        tv[9]  = '{1, 0, 5, 0, 1, 1, 5, 0, 1, 1, 7'b1100001, 3'b100};
        tv[10] = '{1, 0, 5, 0, 1, 1, 5, 1, 1, 0, 7'b1111100, 3'b010};
        tv[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000011, 3'b001};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 3'b000};

        clr();
        ex_redirect = 1; mem_req = 1;
        #2;
        chk("reset_outs", 32'(outs), 0);
        chk("reset_state", 32'(state), 0);
        chk("reset_err", 32'(mem_err), 0);
        chk("reset_cnts", cnt_loaduse | cnt_memwait | cnt_flush, 0);
        @(negedge clk); clr(); reset = 0;

        e_lu = 0; e_mw = 0; e_fl = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            id_valid = tv[i].v; id_rs1 = tv[i].rs1; id_rs2 = tv[i].rs2;
            id_rs1_used = tv[i].u1; id_rs2_used = tv[i].u2; ex_MemRead = tv[i].mr;
            ex_rd = tv[i].rd; ex_redirect = tv[i].red; mem_req = tv[i].mreq; mem_ready = tv[i].mrdy;
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tv[i].exp));
            e_lu += int'(tv[i].cnt[2]); e_mw += int'(tv[i].cnt[1]); e_fl += int'(tv[i].cnt[0]);
        end
        @(negedge clk);
        chk("tbl_cnt_loaduse", cnt_loaduse, 32'(e_lu));
        chk("tbl_cnt_memwait", cnt_memwait, 32'(e_mw));
        chk("tbl_cnt_flush", cnt_flush, 32'(e_fl));
        chk("tbl_state", 32'(state), 0);

        // three-cycle freeze then completion
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("frz%0d_outs", i), 32'(outs), 32'b1111100);
            chk($sformatf("frz%0d_state", i), 32'(state), i == 0 ? 0 : 1);
            @(negedge clk);
        end
        mem_ready = 1; #1;
        chk("frz_done_outs", 32'(outs), 0);
        @(negedge clk); clr(); #1;
        chk("frz_back_state", 32'(state), 0);
        chk("frz_cnt_memwait", cnt_memwait, 3);

        // redirect held through a freeze, flush only on completion
        do_reset();
        mem_req = 1; ex_redirect = 1;
        repeat (2) begin
            #1;
            chk("frzred_noflush", 32'({flush_ifid, flush_idex}), 0);
            @(negedge clk);
        end
        mem_ready = 1; #1;
        chk("frzred_flush", 32'(outs), 32'b0000011);
        @(negedge clk); clr(); #1;
        chk("frzred_drop", 32'(outs), 0);
        @(negedge clk);
        chk("frzred_cnt_flush", cnt_flush, 1);
        chk("frzred_cnt_memwait", cnt_memwait, 2);

        // async reset in MEMWAIT with wait_cnt=7
        do_reset();
        mem_req = 1; ex_redirect = 1;
        repeat (7) @(negedge clk);
        chk("arst_pre_state", 32'(state), 1);
        #2 reset = 1; #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_outs", 32'(outs), 0);
        chk("arst_cnts", cnt_memwait | cnt_flush | cnt_loaduse, 0);
        @(negedge clk); clr(); reset = 0;
        @(negedge clk); #1;
        chk("arst_after_outs", 32'(outs), 0);
        chk("arst_after_state", 32'(state), 0);

        // memory timeout into HALT
        do_reset();
        mem_req = 1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); #1;
            if (i >= 15) begin
                chk($sformatf("to%0d_state", i), 32'(state), i == 16 ? 2 : 1);
                chk($sformatf("to%0d_err", i), 32'(mem_err), i == 16 ? 1 : 0);
            end
        end
        clr(); ex_redirect = 1; mem_ready = 1;
        id_valid = 1; ex_MemRead = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("halt_outs", 32'(outs), 32'b1111100);
        chk("halt_state", 32'(state), 2);
        chk("halt_err", 32'(mem_err), 1);
        chk("halt_cnt_memwait", cnt_memwait, 16);
        chk("halt_cnt_other", cnt_flush | cnt_loaduse, 0);
        do_reset(); #1;
        chk("halt_cleared", 32'({mem_err, state}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
